l2_request_arbiter: RTL and testbench

L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

---
 rtl/cache_config.sv | 30 +++
 rtl/l2_request_arbiter_rr_select.sv | 37 +++
 rtl/l2_request_arbiter.sv | 160 ++++++++++++++++
 tb/tb_l2_request_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_config.sv
// =============================================================================
// cache_config -- shared cache widths, arbiter state and command encodings
// Rev 1.0
// =============================================================================
`default_nettype none

package cache_config;

   localparam int ADDRESS_WIDTH          = 32;
   localparam int DATA_WIDTH             = 32;
   localparam int MAIN_MEMORY_DATA_WIDTH = 128;
   localparam int NUM_PORTS_DEFAULT      = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   // Command latched at grant time; selects which completion is honoured.
   typedef enum logic [1:0] {
      CMD_READ  = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_WB    = 2'd2
   } l2_cmd_t;

endpackage

`default_nettype wire

// File: rtl/l2_request_arbiter_rr_select.sv
// =============================================================================
// rr_select -- combinational round-robin pick: first request at or above ptr,
// wrapping to 0. Rev 1.0
// =============================================================================
`default_nettype none

module rr_select #(
   parameter int NUM_PORTS     = 4,
   parameter int ARB_PTR_WIDTH = 2
) (
   input  logic [NUM_PORTS-1:0]     req_i,
   input  logic [ARB_PTR_WIDTH-1:0] ptr_i,
   output logic [NUM_PORTS-1:0]     gnt_o,
   output logic [ARB_PTR_WIDTH-1:0] idx_o,
   output logic                     valid_o
);

   logic [ARB_PTR_WIDTH-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = ARB_PTR_WIDTH'((int'(ptr_i) + i) % NUM_PORTS);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/l2_request_arbiter.sv
// =============================================================================
// l2_request_arbiter -- round-robin arbiter granting one L1d port the L2 until
// its command completes. Optional macro: L2_ARB_WB_PRIORITY_EN. Rev 1.0
// =============================================================================
`default_nettype none

module l2_request_arbiter
   import cache_config::*;
#(
   parameter int NUM_PORTS     = NUM_PORTS_DEFAULT,
   parameter int ARB_PTR_WIDTH = 2
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [NUM_PORTS-1:0]                                req_read,
   input  logic [NUM_PORTS-1:0]                                req_write,
   input  logic [NUM_PORTS-1:0]                                req_wb,
   input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]             req_addr,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]                req_write_data,
   input  logic [NUM_PORTS-1:0][MAIN_MEMORY_DATA_WIDTH-1:0]    req_wb_data,
   input  logic                                                L2_ready,
   input  logic                                                write_to_L2_verified,
   input  logic                                                write_back_to_L2_verified,
   output logic [ADDRESS_WIDTH-1:0]                            cache_L2_memory_address,
   output logic                                                read_from_L2_request,
   output logic                                                write_to_L2_request,
   output logic                                                write_back_to_L2_request,
   output logic [DATA_WIDTH-1:0]                               l2_write_data,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]                   write_back_to_L2_data,
   output logic [NUM_PORTS-1:0]                                grant,
   output logic [NUM_PORTS-1:0]                                done,
   output logic                                                busy
);

   localparam logic [ARB_PTR_WIDTH-1:0] c_ptr_one  = ARB_PTR_WIDTH'(1);
   localparam logic [ARB_PTR_WIDTH-1:0] c_ptr_last = ARB_PTR_WIDTH'(NUM_PORTS - 1);

   arb_state_t                        state_q, state_d;
   l2_cmd_t                           cmd_q, cmd_d;
   logic [ARB_PTR_WIDTH-1:0]          ptr_q, ptr_d;
   logic [ARB_PTR_WIDTH-1:0]          owner_q, owner_d;
   logic [NUM_PORTS-1:0]              grant_q, grant_d;
   logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
   logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
   logic [MAIN_MEMORY_DATA_WIDTH-1:0] wbdata_q, wbdata_d;

   logic [NUM_PORTS-1:0]              any_req;
   logic [NUM_PORTS-1:0]              arb_req;
   logic [NUM_PORTS-1:0]              sel_gnt;
   logic [ARB_PTR_WIDTH-1:0]          sel_idx;
   logic                              sel_valid;
   logic                              cmd_done;
   logic                              issuing;

   assign any_req = req_read | req_write | req_wb;

`ifdef L2_ARB_WB_PRIORITY_EN
   // Pending victims are drained first; rotation then runs over wb ports only.
   assign arb_req = (|req_wb) ? req_wb : any_req;
`else
   assign arb_req = any_req;
`endif

   rr_select #(
      .NUM_PORTS     (NUM_PORTS),
      .ARB_PTR_WIDTH (ARB_PTR_WIDTH)
   ) u_rr_select (
      .req_i   (arb_req),
      .ptr_i   (ptr_q),
      .gnt_o   (sel_gnt),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   always_comb begin
      case (cmd_q)
         CMD_WRITE: cmd_done = write_to_L2_verified;
         CMD_WB:    cmd_done = write_back_to_L2_verified;
         default:   cmd_done = L2_ready;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wbdata_d = wbdata_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d  = ISSUE;
               grant_d  = sel_gnt;
               owner_d  = sel_idx;
               addr_d   = req_addr[sel_idx];
               wdata_d  = req_write_data[sel_idx];
               wbdata_d = req_wb_data[sel_idx];
               if (req_wb[sel_idx]) begin
                  cmd_d = CMD_WB;
               end else if (req_write[sel_idx]) begin
                  cmd_d = CMD_WRITE;
               end else begin
                  cmd_d = CMD_READ;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (cmd_done) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (owner_q == c_ptr_last) ? '0 : owner_q + c_ptr_one;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cmd_q    <= CMD_READ;
         ptr_q    <= '0;
         owner_q  <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wbdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wbdata_q <= wbdata_d;
      end
   end

   assign issuing                  = (state_q == ISSUE) || (state_q == WAIT);
   assign read_from_L2_request     = issuing && (cmd_q == CMD_READ);
   assign write_to_L2_request      = issuing && (cmd_q == CMD_WRITE);
   assign write_back_to_L2_request = issuing && (cmd_q == CMD_WB);
   assign cache_L2_memory_address  = addr_q;
   assign l2_write_data            = wdata_q;
   assign write_back_to_L2_data    = wbdata_q;
   assign grant                    = grant_q;
   assign done                     = (state_q == RELEASE) ? grant_q : '0;
   assign busy                     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
// =============================================================================
// tb_l2_request_arbiter -- directed scoreboard bench for l2_request_arbiter
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_l2_request_arbiter;
   import cache_config::*;

   localparam int NP = 4;
   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int MW = MAIN_MEMORY_DATA_WIDTH;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NP-1:0]          req_read, req_write, req_wb;
   logic [NP-1:0][AW-1:0]  req_addr;
   logic [NP-1:0][DW-1:0]  req_write_data;
   logic [NP-1:0][MW-1:0]  req_wb_data;
   logic                   L2_ready, write_to_L2_verified, write_back_to_L2_verified;
   logic [AW-1:0]          cache_L2_memory_address;
   logic                   read_from_L2_request, write_to_L2_request, write_back_to_L2_request;
   logic [DW-1:0]          l2_write_data;
   logic [MW-1:0]          write_back_to_L2_data;
   logic [NP-1:0]          grant, done;
   logic                   busy;

   l2_request_arbiter #(.NUM_PORTS(NP), .ARB_PTR_WIDTH(2)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .req_read                  (req_read),
      .req_write                 (req_write),
      .req_wb                    (req_wb),
      .req_addr                  (req_addr),
      .req_write_data            (req_write_data),
      .req_wb_data               (req_wb_data),
      .L2_ready                  (L2_ready),
      .write_to_L2_verified      (write_to_L2_verified),
      .write_back_to_L2_verified (write_back_to_L2_verified),
      .cache_L2_memory_address   (cache_L2_memory_address),
      .read_from_L2_request      (read_from_L2_request),
      .write_to_L2_request       (write_to_L2_request),
      .write_back_to_L2_request  (write_back_to_L2_request),
      .l2_write_data             (l2_write_data),
      .write_back_to_L2_data     (write_back_to_L2_data),
      .grant                     (grant),
      .done                      (done),
      .busy                      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    port;
      int            cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wbdata;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [2:0] reqv();
      return {write_back_to_L2_request, write_to_L2_request, read_from_L2_request};
   endfunction

   function automatic logic [NP-1:0] onehot(input logic [1:0] p);
      return NP'(1) << p;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_grant"}, MW'(grant), '0);
      chk({tag, "_done"},  MW'(done), '0);
      chk({tag, "_busy"},  MW'(busy), '0);
      chk({tag, "_req"},   MW'(reqv()), '0);
      chk({tag, "_addr"},  MW'(cache_L2_memory_address), '0);
      chk({tag, "_wdata"}, MW'(l2_write_data), '0);
      chk({tag, "_wbdata"}, write_back_to_L2_data, '0);
   endtask

   task automatic drive(input logic [1:0] p, input int cmd, input logic [AW-1:0] a);
      req_addr[p]       = a;
      req_write_data[p] = ~a;
      req_wb_data[p]    = {a, ~a, a ^ 32'h0F0F_0F0F, 30'd0, p};
      case (cmd)
         0:       req_read[p]  = 1'b1;
         1:       req_write[p] = 1'b1;
         default: req_wb[p]    = 1'b1;
      endcase
   endtask

   task automatic expect_grant(input logic [1:0] p, input int cmd);
      exp_t e;
      e.port   = p;
      e.cmd    = cmd;
      e.addr   = req_addr[p];
      e.wdata  = req_write_data[p];
      e.wbdata = req_wb_data[p];
      sb.push_back(e);
   endtask

   task automatic wait_issue(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 20) begin
         @(negedge clk);
         lat++;
         if (reqv() != 3'b000) ok = 1'b1;
      end
      chk("issue_seen", MW'(ok), MW'(1));
   endtask

   task automatic check_latched(input string tag, input exp_t e);
      chk({tag, "_grant"}, MW'(grant), MW'(onehot(e.port)));
      chk({tag, "_cmd"},   MW'(reqv()), MW'(3'b001 << e.cmd));
      chk({tag, "_addr"},  MW'(cache_L2_memory_address), MW'(e.addr));
      chk({tag, "_done"},  MW'(done), '0);
      if (e.cmd == 1) chk({tag, "_wdata"}, MW'(l2_write_data), MW'(e.wdata));
      if (e.cmd == 2) chk({tag, "_wbdata"}, write_back_to_L2_data, e.wbdata);
   endtask

   // One full transaction: issue, hold through WAIT (owner drops/scrambles its
   // inputs), completion after `delay` WAIT cycles, done pulse, back to IDLE.
   task automatic serve(input int exp_lat, input int delay, input bit noise);
      int   lat;
      bit   ok;
      exp_t e;
      wait_issue(lat, ok);
      if (!ok) return;
      chk("sb_nonempty", MW'(sb.size() > 0), MW'(1));
      if (sb.size() == 0) return;
      e = sb.pop_front();
      if (exp_lat >= 0) chk("latency", MW'(lat), MW'(exp_lat));
      chk("busy_issue", MW'(busy), MW'(1));
      check_latched("issue", e);
      case (e.cmd)
         0:       req_read[e.port]  = 1'b0;
         1:       req_write[e.port] = 1'b0;
         default: req_wb[e.port]    = 1'b0;
      endcase
      req_addr[e.port]       = ~e.addr;
      req_write_data[e.port] = ~e.wdata;
      req_wb_data[e.port]    = ~e.wbdata;
      for (int k = 0; k < delay; k++) begin
         @(negedge clk);
         check_latched("wait", e);
         L2_ready                  = (e.cmd == 0) ? (k == delay - 1) : noise;
         write_to_L2_verified      = (e.cmd == 1) ? (k == delay - 1) : noise;
         write_back_to_L2_verified = (e.cmd == 2) ? (k == delay - 1) : noise;
      end
      @(negedge clk);
      L2_ready                  = 1'b0;
      write_to_L2_verified      = 1'b0;
      write_back_to_L2_verified = 1'b0;
      chk("done_pulse", MW'(done), MW'(onehot(e.port)));
      chk("release_req", MW'(reqv()), '0);
      chk("release_grant", MW'(grant), MW'(onehot(e.port)));
      req_addr[e.port]       = e.addr;
      req_write_data[e.port] = e.wdata;
      req_wb_data[e.port]    = e.wbdata;
      @(negedge clk);
      chk("idle_done", MW'(done), '0);
      chk("idle_grant", MW'(grant), '0);
      chk("idle_busy", MW'(busy), '0);
   endtask

   initial begin
      int   lat;
      bit   ok;
      exp_t e;

      reset                     = 1'b0;
      req_read                  = '0;
      req_write                 = '0;
      req_wb                    = '0;
      req_addr                  = '0;
      req_write_data            = '0;
      req_wb_data               = '0;
      L2_ready                  = 1'b0;
      write_to_L2_verified      = 1'b0;
      write_back_to_L2_verified = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Contention from pointer 0: strict order 0,1,2,3, minimum latency.
      for (int p = 0; p < NP; p++) drive(2'(p), 0, 32'h1000_0000 + 32'(p) * 32'h40);
      for (int p = 0; p < NP; p++) expect_grant(2'(p), 0);
      for (int p = 0; p < NP; p++) serve(1, 1, 1'b0);

      // Single read on port 2, completion after 3 WAIT cycles.
      drive(2'd2, 0, 32'hC000_1040);
      expect_grant(2'd2, 0);
      serve(1, 3, 1'b0);

      // Pointer now 3: port 3 before port 0.
      drive(2'd0, 0, 32'h0000_0A00);
      drive(2'd3, 0, 32'h0000_0B00);
      expect_grant(2'd3, 0);
      expect_grant(2'd0, 0);
      serve(1, 1, 1'b0);
      serve(1, 2, 1'b0);

      // Pointer 1; serve port 3 alone to bring it back to 0.
      drive(2'd3, 0, 32'h0000_0C00);
      expect_grant(2'd3, 0);
      serve(1, 1, 1'b0);

      // Read on port 1 vs write-back on port 2 from pointer 0.
      drive(2'd1, 0, 32'h2222_1100);
      drive(2'd2, 2, 32'h3333_2200);
`ifdef L2_ARB_WB_PRIORITY_EN
      expect_grant(2'd2, 2);
      expect_grant(2'd1, 0);
`else
      expect_grant(2'd1, 0);
      expect_grant(2'd2, 2);
`endif
      serve(1, 2, 1'b1);
      serve(1, 1, 1'b0);

      // One port with all three commands: wb, then write, then read.
      drive(2'd0, 2, 32'h4444_0080);
      drive(2'd0, 1, 32'h4444_0080);
      drive(2'd0, 0, 32'h4444_0080);
      expect_grant(2'd0, 2);
      expect_grant(2'd0, 1);
      expect_grant(2'd0, 0);
      serve(1, 1, 1'b0);
      serve(1, 4, 1'b1);
      serve(1, 1, 1'b1);

      // Reset during WAIT abandons the write with no done pulse.
      drive(2'd2, 1, 32'h5555_0040);
      expect_grant(2'd2, 1);
      wait_issue(lat, ok);
      e = sb.pop_front();
      chk("rst_pre_grant", MW'(grant), MW'(onehot(e.port)));
      req_write[2] = 1'b0;
      @(negedge clk);
      chk("rst_pre_wait", MW'(write_to_L2_request), MW'(1));
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      reset                = 1'b1;
      write_to_L2_verified = 1'b1;
      @(negedge clk);
      write_to_L2_verified = 1'b0;
      chk("post_rst_done", MW'(done), '0);
      chk("post_rst_busy", MW'(busy), '0);

      // Pointer cleared by reset: port 0 ahead of port 1.
      drive(2'd1, 0, 32'h6666_0100);
      drive(2'd0, 0, 32'h6666_0000);
      expect_grant(2'd0, 0);
      expect_grant(2'd1, 0);
      serve(1, 1, 1'b0);
      serve(1, 1, 1'b0);

      chk("sb_drained", MW'(sb.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
